// File: rtl/sm_tc_convert_pipe_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sm_tc_convert_pipe_pkg
// Description : Shared definitions for the sign-magnitude / two's-complement
//               converter.
//               - Mode encodings.
//               - Saturation constants, derived from the lane width.
//               - Lane-slice helper.
// Revision    : 1.0 - initial release
// ============================================================================
package sm_tc_convert_pipe_pkg;

  localparam logic MODE_SM2TC = 1'b0;
  localparam logic MODE_TC2SM = 1'b1;

  // Largest positive two's-complement value in an n-bit word: 2^(n-1)-1.
  function automatic int max_pos(input int n);
    return (1 << (n - 1)) - 1;
  endfunction

  // Magnitude of the most negative n-bit word: 2^(n-1).
  function automatic int min_neg(input int n);
    return 1 << (n - 1);
  endfunction

  // Low bit index of lane 'lane' in a packed vector of n-bit lanes.
  function automatic int lane_lo(input int lane, input int n);
    return lane * n;
  endfunction

endpackage
`default_nettype wire

// File: rtl/sm_tc_lane.sv
`default_nettype none
// ============================================================================
// Module      : sm_tc_lane
// Description : Per-lane combinational logic of the converter.
//               Stage-1 half:
//                 - XOR of the word with the effective sign.
//                 - Effective sign.
//                 - Overflow pre-check.
//               Stage-2 half:
//                 - +1 increment.
//                 - Saturation mux.
// Ports       : i_mode/i_data/i_sign -> o_s1_x/o_s1_sign/o_s1_ovf (to S1 regs)
//               i_s2_x/i_s2_sign/i_s2_ovf (from S1 regs) -> o_s2_data
// Revision    : 1.0 - initial release
// ============================================================================
module sm_tc_lane
  import sm_tc_convert_pipe_pkg::*;
#(
  parameter int N = 5
) (
  input  logic         i_mode,
  input  logic [N-1:0] i_data,
  input  logic         i_sign,
  output logic [N-1:0] o_s1_x,
  output logic         o_s1_sign,
  output logic         o_s1_ovf,
  input  logic [N-1:0] i_s2_x,
  input  logic         i_s2_sign,
  input  logic         i_s2_ovf,
  output logic [N-1:0] o_s2_data
);

  localparam logic [N-1:0] c_max_pos = N'(max_pos(N));
  localparam logic [N-1:0] c_min_neg = N'(min_neg(N));

  logic         w_sign;
  logic         w_ovf_pos;
  logic         w_ovf_neg;
  logic [N-1:0] w_inc;

  // Both directions share one datapath: negate when the effective sign is
  // set. In TC2SM the sign is the word's msb, in SM2TC it is the input sign.
  assign w_sign    = (i_mode == MODE_TC2SM) ? i_data[N-1] : i_sign;
  assign o_s1_x    = i_data ^ {N{w_sign}};
  assign o_s1_sign = w_sign;

  // Only SM2TC can overflow. A positive magnitude with its msb set does not
  // fit. A negative magnitude fits only up to 2^(N-1).
  assign w_ovf_pos = ~i_sign & i_data[N-1];
  assign w_ovf_neg = i_sign & (i_data > c_min_neg);
  assign o_s1_ovf  = (i_mode == MODE_SM2TC) & (w_ovf_pos | w_ovf_neg);

  assign w_inc     = i_s2_x + N'(i_s2_sign);
  assign o_s2_data = i_s2_ovf ? (i_s2_sign ? c_min_neg : c_max_pos) : w_inc;

endmodule
`default_nettype wire

// File: rtl/sm_tc_convert_pipe.sv
`default_nettype none
// ============================================================================
// Module      : sm_tc_convert_pipe
// Description : Two-stage pipelined, multi-lane converter between
//               sign-magnitude and two's-complement.
//               - Mode is selected per transaction and travels with the data.
//               - Results that cannot be represented are saturated and flagged.
//               - A saturating counter tracks overflowed lanes.
// Ports       : clk, rst (async, active-low)
//               in_valid/in_ready/in_mode/in_data/in_sign  - upstream
//               out_valid/out_ready/out_mode/out_data/out_sign/out_ovf
//                                                          - downstream
//               ovf_count, cnt_clear                       - overflow counter
// Revision    : 1.0 - initial release
// ============================================================================
module sm_tc_convert_pipe
  import sm_tc_convert_pipe_pkg::*;
#(
  parameter int N     = 5,
  parameter int LANES = 2,
  parameter int CNT_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               in_mode,
  input  logic [LANES*N-1:0] in_data,
  input  logic [LANES-1:0]   in_sign,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               out_mode,
  output logic [LANES*N-1:0] out_data,
  output logic [LANES-1:0]   out_sign,
  output logic [LANES-1:0]   out_ovf,
  output logic [CNT_W-1:0]   ovf_count,
  input  logic               cnt_clear
);

  localparam int               c_pc_w    = $clog2(LANES + 1);
  localparam int               c_sum_w   = CNT_W + c_pc_w;
  localparam logic [CNT_W-1:0] c_cnt_max = '1;

  logic               r_s1_valid;
  logic               r_s1_mode;
  logic [LANES*N-1:0] r_s1_x;
  logic [LANES-1:0]   r_s1_sign;
  logic [LANES-1:0]   r_s1_ovf;

  logic               r_s2_valid;
  logic               r_s2_mode;
  logic [LANES*N-1:0] r_s2_data;
  logic [LANES-1:0]   r_s2_sign;
  logic [LANES-1:0]   r_s2_ovf;

  logic [CNT_W-1:0]   r_ovf_count;

  logic [LANES*N-1:0] w_s1_x;
  logic [LANES-1:0]   w_s1_sign;
  logic [LANES-1:0]   w_s1_ovf;
  logic [LANES*N-1:0] w_s2_data;
  logic               w_s2_load;
  logic               w_s1_load;
  logic [c_pc_w-1:0]  w_pop;
  logic [c_sum_w-1:0] w_sum;
  logic [CNT_W-1:0]   w_cnt_next;

  generate
    for (genvar i = 0; i < LANES; i++) begin : g_lane
      localparam int c_lo = lane_lo(i, N);
      sm_tc_lane #(.N(N)) u_lane (
        .i_mode    (in_mode),
        .i_data    (in_data[c_lo +: N]),
        .i_sign    (in_sign[i]),
        .o_s1_x    (w_s1_x[c_lo +: N]),
        .o_s1_sign (w_s1_sign[i]),
        .o_s1_ovf  (w_s1_ovf[i]),
        .i_s2_x    (r_s1_x[c_lo +: N]),
        .i_s2_sign (r_s1_sign[i]),
        .i_s2_ovf  (r_s1_ovf[i]),
        .o_s2_data (w_s2_data[c_lo +: N])
      );
    end
  endgenerate

  // Each stage advances when its successor has room. in_ready therefore
  // depends combinationally on out_ready. This gives full throughput
  // without any skid buffer.
  assign w_s2_load = ~r_s2_valid | out_ready;
  assign w_s1_load = ~r_s1_valid | w_s2_load;
  assign in_ready  = w_s1_load;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_s1_valid <= 1'b0;
      r_s1_mode  <= 1'b0;
      r_s1_x     <= '0;
      r_s1_sign  <= '0;
      r_s1_ovf   <= '0;
    end else if (w_s1_load) begin
      r_s1_valid <= in_valid;
      if (in_valid) begin
        r_s1_mode <= in_mode;
        r_s1_x    <= w_s1_x;
        r_s1_sign <= w_s1_sign;
        r_s1_ovf  <= w_s1_ovf;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_s2_valid <= 1'b0;
      r_s2_mode  <= 1'b0;
      r_s2_data  <= '0;
      r_s2_sign  <= '0;
      r_s2_ovf   <= '0;
    end else if (w_s2_load) begin
      r_s2_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_s2_mode <= r_s1_mode;
        r_s2_data <= w_s2_data;
        r_s2_sign <= r_s1_sign;
        r_s2_ovf  <= r_s1_ovf;
      end
    end
  end

  // The sum is wide enough that a full counter plus all lanes cannot wrap
  // before the saturation compare.
  always_comb begin
    w_pop = '0;
    for (int i = 0; i < LANES; i++) begin
      w_pop = w_pop + c_pc_w'(r_s2_ovf[i]);
    end
    w_sum      = c_sum_w'(r_ovf_count) + c_sum_w'(w_pop);
    w_cnt_next = (w_sum > c_sum_w'(c_cnt_max)) ? c_cnt_max : w_sum[CNT_W-1:0];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_ovf_count <= '0;
    end else if (cnt_clear) begin
      r_ovf_count <= '0;
    end else if (r_s2_valid && out_ready) begin
      r_ovf_count <= w_cnt_next;
    end
  end

  assign out_valid = r_s2_valid;
  assign out_mode  = r_s2_mode;
  assign out_data  = r_s2_data;
  assign out_sign  = r_s2_sign;
  assign out_ovf   = r_s2_ovf;
  assign ovf_count = r_ovf_count;

endmodule
`default_nettype wire

// File: tb/tb_sm_tc_convert_pipe.sv
`default_nettype none
// ============================================================================
// Module      : tb_sm_tc_convert_pipe
// Description : Self-checking bench for sm_tc_convert_pipe (N=5, LANES=2,
//               CNT_W=2).
//               - An arithmetic reference model feeds a scoreboard that is
//                 compared every cycle.
//               - Directed vectors carry literal expectations.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sm_tc_convert_pipe;

  localparam int N     = 5;
  localparam int LANES = 2;
  localparam int CNT_W = 2;
  localparam int LW    = LANES * N;
  localparam int CMAX  = (1 << CNT_W) - 1;

  typedef struct packed {
    logic             mode;
    logic [LW-1:0]    data;
    logic [LANES-1:0] sign;
    logic [LANES-1:0] ovf;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic             in_mode = 1'b0;
  logic [LW-1:0]    in_data = '0;
  logic [LANES-1:0] in_sign = '0;
  logic             out_valid;
  logic             out_ready = 1'b1;
  logic             out_mode;
  logic [LW-1:0]    out_data;
  logic [LANES-1:0] out_sign;
  logic [LANES-1:0] out_ovf;
  logic [CNT_W-1:0] ovf_count;
  logic             cnt_clear = 1'b0;

  int checks = 0;
  int errors = 0;

  exp_t             q[$];
  int               occ  = 0;
  int               mcnt = 0;
  logic             hold = 1'b0;
  logic             snap_mode;
  logic [LW-1:0]    snap_data;
  logic [LANES-1:0] snap_sign;
  logic [LANES-1:0] snap_ovf;

  sm_tc_convert_pipe #(.N(N), .LANES(LANES), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_mode   (in_mode),
    .in_data   (in_data),
    .in_sign   (in_sign),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_mode  (out_mode),
    .out_data  (out_data),
    .out_sign  (out_sign),
    .out_ovf   (out_ovf),
    .ovf_count (ovf_count),
    .cnt_clear (cnt_clear)
  );

  always #5 clk = ~clk;

  // Reference: interpret each lane as a signed integer, clamp it to the
  // representable range, then re-encode it.
  function automatic exp_t model(input logic m, input logic [LW-1:0] d,
                                 input logic [LANES-1:0] s);
    exp_t e;
    int   v;
    int   lim;
    lim    = 1 << (N - 1);
    e.mode = m;
    e.data = '0;
    e.sign = '0;
    e.ovf  = '0;
    for (int i = 0; i < LANES; i++) begin
      v = int'(d[i*N +: N]);
      if (m == 1'b0) begin
        if (s[i]) v = -v;
        e.sign[i] = s[i];
        if (v > lim - 1) begin
          v = lim - 1;
          e.ovf[i] = 1'b1;
        end else if (v < -lim) begin
          v = -lim;
          e.ovf[i] = 1'b1;
        end
      end else begin
        if (v >= lim) v = v - 2 * lim;
        e.sign[i] = (v < 0);
        if (v < 0) v = -v;
      end
      e.data[i*N +: N] = v[N-1:0];
    end
    return e;
  endfunction

  function automatic int csat(input int x);
    return (x > CMAX) ? CMAX : x;
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      q.delete();
      occ  <= 0;
      mcnt <= 0;
      hold <= 1'b0;
    end else begin
      hold      <= out_valid && !out_ready;
      snap_mode <= out_mode;
      snap_data <= out_data;
      snap_sign <= out_sign;
      snap_ovf  <= out_ovf;
      if (cnt_clear)
        mcnt <= 0;
      else if (out_valid && out_ready && q.size() > 0)
        mcnt <= csat(mcnt + $countones(q[0].ovf));
      if (out_valid && out_ready && q.size() > 0) q.delete(0);
      if (in_valid && in_ready) q.push_back(model(in_mode, in_data, in_sign));
      occ <= occ + ((in_valid && in_ready) ? 1 : 0)
                 - ((out_valid && out_ready) ? 1 : 0);
    end
  end

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // One cycle: wait for the falling edge, then compare the DUT against the model.
  task automatic tick();
    exp_t h;
    @(negedge clk);
    if (rst) begin
      chk("in_ready", int'(in_ready), int'(!(occ == 2 && !out_ready)));
      chk("ovf_count", int'(ovf_count), mcnt);
      if (out_valid) begin
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL spurious_out: out_valid=1 with no transaction expected");
        end else begin
          h = q[0];
          chk("out_data", int'(out_data), int'(h.data));
          chk("out_sign", int'(out_sign), int'(h.sign));
          chk("out_ovf", int'(out_ovf), int'(h.ovf));
          chk("out_mode", int'(out_mode), int'(h.mode));
        end
        if (hold) chk("stall_data", int'(out_data), int'(snap_data));
        if (hold) chk("stall_sign", int'(out_sign), int'(snap_sign));
        if (hold) chk("stall_ovf", int'(out_ovf), int'(snap_ovf));
        if (hold) chk("stall_mode", int'(out_mode), int'(snap_mode));
      end else if (hold) begin
        chk("stall_valid", int'(out_valid), 1);
      end
    end
  endtask

  // rmode: 0 = out_ready high, 1 = random out_ready, 2 = out_ready low.
  task automatic push(input logic m, input logic [LW-1:0] d,
                      input logic [LANES-1:0] s, input int rmode);
    int guard;
    bit done;
    guard = 0;
    done  = 1'b0;
    while (!done) begin
      tick();
      #1;
      in_valid  = 1'b1;
      in_mode   = m;
      in_data   = d;
      in_sign   = s;
      out_ready = (rmode == 1) ? 1'($urandom_range(0, 1)) : (rmode == 0);
      #1;
      if (in_ready) begin
        @(posedge clk);
        done = 1'b1;
      end else begin
        guard++;
        if (guard > 50) begin
          checks++;
          errors++;
          $display("FAIL push_timeout: in_ready stayed 0 for %0d cycles", guard);
          done = 1'b1;
        end
      end
    end
  endtask

  task automatic direct(input string nm, input logic m, input logic [LW-1:0] d,
                        input logic [LANES-1:0] s, input logic [LW-1:0] ed,
                        input logic [LANES-1:0] es, input logic [LANES-1:0] eo,
                        input int ecnt);
    push(m, d, s, 0);
    tick();
    chk({nm, "_lat1_valid"}, int'(out_valid), 0);
    #1;
    in_valid = 1'b0;
    tick();
    chk({nm, "_valid"}, int'(out_valid), 1);
    chk({nm, "_data"}, int'(out_data), int'(ed));
    chk({nm, "_sign"}, int'(out_sign), int'(es));
    chk({nm, "_ovf"}, int'(out_ovf), int'(eo));
    chk({nm, "_mode"}, int'(out_mode), int'(m));
    tick();
    chk({nm, "_count"}, int'(ovf_count), ecnt);
    #1;
  endtask

  initial begin
    int g;
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int g;
    repeat (2) @(negedge clk);
    chk("reset_out_valid", int'(out_valid), 0);
    chk("reset_out_data", int'(out_data), 0);
    chk("reset_ovf_count", int'(ovf_count), 0);
    #1;
    rst = 1'b1;
    tick();
    chk("reset_in_ready", int'(in_ready), 1);
    #1;

    direct("sm2tc_basic", 1'b0, {5'd16, 5'd3}, 2'b11,
           {5'b10000, 5'b11101}, 2'b11, 2'b00, 0);
    direct("sm2tc_sat", 1'b0, {5'd20, 5'd16}, 2'b10,
           {5'b10000, 5'b01111}, 2'b10, 2'b11, 2);
    direct("sm2tc_negzero", 1'b0, {5'd5, 5'd0}, 2'b01,
           {5'd5, 5'd0}, 2'b01, 2'b00, 2);
    direct("tc2sm_min", 1'b1, {5'b11101, 5'b10000}, 2'b00,
           {5'd3, 5'd16}, 2'b11, 2'b00, 2);
    direct("tc2sm_pos", 1'b1, {5'b11111, 5'b00101}, 2'b11,
           {5'd1, 5'd5}, 2'b10, 2'b00, 2);
    direct("sm2tc_edge", 1'b0, {5'd17, 5'd15}, 2'b10,
           {5'b10000, 5'b01111}, 2'b10, 2'b10, 3);

    // Back-to-back stream, alternating modes, random backpressure.
    for (int k = 0; k < 8; k++) begin
      push(k[0], LW'($urandom), LANES'($urandom), 1);
    end
    tick();
    #1;
    in_valid = 1'b0;
    g = 0;
    while (q.size() != 0 && g < 200) begin
      out_ready = 1'($urandom_range(0, 1));
      tick();
      #1;
      g++;
    end
    chk("stream_drained", q.size(), 0);
    out_ready = 1'b1;

    // Asynchronous reset with two transactions in flight.
    push(1'b0, {5'd20, 5'd16}, 2'b10, 2);
    push(1'b1, {5'b10011, 5'b00111}, 2'b00, 2);
    tick();
    #1;
    in_valid = 1'b0;
    rst = 1'b0;
    #1;
    chk("async_rst_out_valid", int'(out_valid), 0);
    chk("async_rst_ovf_count", int'(ovf_count), 0);
    chk("async_rst_out_data", int'(out_data), 0);
    tick();
    #1;
    out_ready = 1'b1;
    rst = 1'b1;
    direct("post_reset", 1'b0, {5'd1, 5'd7}, 2'b01,
           {5'b00001, 5'b11001}, 2'b01, 2'b00, 0);

    // Counter saturation at 2^CNT_W-1.
    direct("cnt_sat1", 1'b0, {5'd31, 5'd16}, 2'b10,
           {5'b10000, 5'b01111}, 2'b10, 2'b11, 2);
    direct("cnt_sat2", 1'b0, {5'd31, 5'd16}, 2'b10,
           {5'b10000, 5'b01111}, 2'b10, 2'b11, 3);
    direct("cnt_sat3", 1'b0, {5'd31, 5'd16}, 2'b10,
           {5'b10000, 5'b01111}, 2'b10, 2'b11, 3);

    // Clear in the same cycle as an overflowing output transfer.
    push(1'b0, {5'd31, 5'd16}, 2'b10, 2);
    tick();
    #1;
    in_valid = 1'b0;
    tick();
    chk("clear_pending_valid", int'(out_valid), 1);
    #1;
    cnt_clear = 1'b1;
    out_ready = 1'b1;
    tick();
    chk("clear_count", int'(ovf_count), 0);
    chk("clear_consumed", int'(out_valid), 0);
    #1;
    cnt_clear = 1'b0;
    repeat (3) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/sm_tc_convert_pipe.md
Name: sm_tc_convert_pipe

Overview:
Pipelined, multi-lane converter between sign-magnitude and two's-complement, parametrised in width and lane count.
- Selects direction per transaction, in either direction: sign-magnitude to two's-complement, or two's-complement to sign-magnitude.
- Saturates and flags results that cannot be represented.
- Counts overflow events.
- Sits between datapath stages that use different number formats, with valid/ready handshake on both sides.

Parameters:
N, 5, bit width of each lane's magnitude / two's-complement word
LANES, 2, number of independent lanes processed in parallel per transaction
CNT_W, 8, width of the saturating overflow-event counter

Ports:
clk  in  1  clock, rising-edge
rst  in  1  asynchronous, active-low reset
in_valid  in  1  input transaction valid
in_ready  out  1  converter can accept a transaction this cycle
in_mode  in  1  0 = sign-magnitude to two's-complement (SM2TC), 1 = two's-complement to sign-magnitude (TC2SM)
in_data  in  LANES*N  per lane: magnitude (SM2TC) or two's-complement word (TC2SM); lane i = bits [i*N +: N]
in_sign  in  LANES  per-lane sign bit (SM2TC only; ignored in TC2SM)
out_valid  out  1  output transaction valid
out_ready  in  1  downstream accepts output
out_mode  out  1  mode the output transaction was converted with
out_data  out  LANES*N  per lane: two's-complement result (SM2TC) or magnitude (TC2SM)
out_sign  out  LANES  per lane: sign of result (TC2SM); copy of input sign (SM2TC)
out_ovf  out  LANES  per lane: result saturated
ovf_count  out  CNT_W  number of lanes that overflowed since reset or clear
cnt_clear  in  1  synchronous clear of ovf_count

Behaviour:
- Reset (rst=0, asynchronous): both stage valids = 0; out_valid = 0; out_data, out_sign, out_ovf, out_mode = 0; ovf_count = 0. in_ready is 1 one cycle after reset deasserts.
- Handshakes: transfer on in_valid & in_ready and on out_valid & out_ready.
- Data stability: out_* hold stable while out_valid=1 and out_ready=0.
- Pipeline: two register stages, S1 and S2.
  - S1 registers the lane data XORed with the effective sign, the effective sign itself, the mode and an overflow pre-check.
  - S2 registers the +1 increment, the saturation mux and out_ovf.
- Latency and throughput: latency 2 cycles from input transfer to out_valid. Throughput 1 transaction/cycle while out_ready=1.
- Stall rule: S2 loads when !S2.valid | out_ready. S1 loads when !S1.valid | (S2 loads). in_ready = !S1.valid | (S2 loads), which is combinational from out_ready.
- No bubble insertion and no transaction loss under any out_ready pattern.
- SM2TC, per lane (mag = N-bit unsigned, s = sign):
  - s=0, mag <= 2^(N-1)-1: out = mag.
  - s=1, mag <= 2^(N-1): out = (~mag)+1, truncated to N bits.
  - s=1, mag=0 (negative zero): out = 0, ovf=0.
  - s=0, mag >= 2^(N-1): out = 2^(N-1)-1, ovf=1.
  - s=1, mag > 2^(N-1): out = -2^(N-1), i.e. 1 followed by N-1 zeros, ovf=1.
  - out_sign = s.
- TC2SM, per lane: out_sign = msb of the word. out_data = word if msb=0, else (~word)+1 as N-bit unsigned. -2^(N-1) maps to magnitude 2^(N-1) and is representable. ovf is always 0.
- ovf_count:
  - On each S2 output transfer, adds popcount(out_ovf), saturating at 2^CNT_W-1.
  - cnt_clear has priority: count becomes 0 on that edge, and that cycle's increment is dropped.
- Reset mid-operation: in-flight transactions are discarded and no partial output is presented.
- Mode change between back-to-back transactions needs no idle cycle, because mode travels with the data.

Decomposition:
- Shared package holds: MODE_SM2TC = 1'b0, MODE_TC2SM = 1'b1; saturation constants derived from N (MAX_POS = 2^(N-1)-1, MIN_NEG = 2^(N-1)); lane-slice helper.
- Sub-module sm_tc_lane holds the per-lane combinational logic:
  - stage-1 XOR / effective sign / overflow pre-check;
  - stage-2 increment and saturate.
- The top instantiates LANES copies via generate and owns all registers, handshake and counter.

Test Plan (N=5, LANES=2):
- SM2TC lane0 mag=3 s=1, lane1 mag=16 s=1, out_ready=1 -> 2 cycles later out_data lanes = 5'b11101, 5'b10000; out_ovf=00; ovf_count=0.
- SM2TC lane0 mag=16 s=0, lane1 mag=20 s=1 -> 5'b01111, 5'b10000; out_ovf=11; ovf_count=2. Then lane0 mag=0 s=1 -> 5'b00000, ovf=0.
- TC2SM lane0=5'b10000, lane1=5'b11101 -> magnitudes 16 and 3, out_sign=11, out_ovf=00. Input 5'b00101 -> magnitude 5, sign 0.
- Back-to-back stream of 8 transactions with alternating modes, out_ready toggled randomly -> all 8 emerged in order with correct values, out_* stable during stalls, in_ready low only when both stages are full and out_ready=0.
- Drive rst low while 2 transactions are in flight -> out_valid=0 and ovf_count=0 immediately (async). After release, the next transaction converts correctly.
- ovf_count: with CNT_W=2, drive 3 both-lane-overflow transactions -> saturates at 3. Assert cnt_clear in the same cycle as an overflow output -> count = 0.
